// File: rtl/lfsr_prpg_core_if.sv
// lfsr_prpg_core_if
// Bundles the control/status signals of the LFSR pattern-generator core.
//   start    : one-cycle pulse that launches program execution
//   instr    : instruction word at pc, {opcode[5:0], operand[WIDTH-1:0]}
//   data_in  : MISR compaction data, sampled on every shift step
//   pc       : current instruction address
//   q        : LFSR register
//   r_addr   : pattern-memory address register
//   q_vld    : high in the cycle q holds a freshly shifted value
//   busy, halted, lock_err, ill_op : status flags
// Modport master is the sequencer/ROM side, modport slave is the core.
interface lfsr_prpg_core_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int PC_W   = 8
);
    logic               start;
    logic [WIDTH+5:0]   instr;
    logic [WIDTH-1:0]   data_in;
    logic [PC_W-1:0]    pc;
    logic [WIDTH-1:0]   q;
    logic [ADDR_W-1:0]  r_addr;
    logic               q_vld;
    logic               busy;
    logic               halted;
    logic               lock_err;
    logic               ill_op;

    modport master (
        output start, instr, data_in,
        input  pc, q, r_addr, q_vld, busy, halted, lock_err, ill_op
    );

    modport slave (
        input  start, instr, data_in,
        output pc, q, r_addr, q_vld, busy, halted, lock_err, ill_op
    );
endinterface

// File: rtl/lfsr_prpg_core.sv
// lfsr_prpg_core
// Small programmable pseudo-random pattern generator: executes one
// instruction per cycle from an external ROM, driving a Galois/Fibonacci
// LFSR (optionally as a MISR), a pattern memory and an address register.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (pattern memory is not reset)
//   bus   : lfsr_prpg_core_if.slave (start/instr/data_in in; pc, q,
//           r_addr, q_vld, busy, halted, lock_err, ill_op out)
module lfsr_prpg_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int PC_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    lfsr_prpg_core_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [5:0] OP_CFG_TAP   = 6'h01;
    localparam logic [5:0] OP_INIT_L    = 6'h02;
    localparam logic [5:0] OP_RUN       = 6'h03;
    localparam logic [5:0] OP_STORE     = 6'h04;
    localparam logic [5:0] OP_LOAD      = 6'h05;
    localparam logic [5:0] OP_INIT_ADDR = 6'h06;
    localparam logic [5:0] OP_ADD_ADDR  = 6'h07;
    localparam logic [5:0] OP_SET_MODE  = 6'h08;
    localparam logic [5:0] OP_HALT      = 6'h3F;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RUN, S_HALT} state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     pc, pc_nxt;
    logic [WIDTH-1:0]    q, q_nxt;
    logic [WIDTH-1:0]    tap, tap_nxt;
    logic [WIDTH-1:0]    cnt, cnt_nxt;
    logic [1:0]          mode, mode_nxt;
    logic [ADDR_W-1:0]   r_addr, r_addr_nxt;
    logic                q_vld, lock_err, ill_op;
    logic                step_en, step_lock, ill_set, mem_we;
    logic [WIDTH-1:0]    step_q;
    logic [5:0]          opcode;
    logic [WIDTH-1:0]    operand;
    logic [WIDTH-1:0]    mem [DEPTH];

    // One shift step. Galois feeds the MSB back into every tapped stage
    // (tap[0] has no stage in front of it and is ignored); Fibonacci
    // shifts left with the parity of the tapped bits, MSB always tapped.
    function automatic logic [WIDTH-1:0] lfsr_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tp,
        input logic [1:0]       md,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] tap_f;
        if (md[0]) begin
            tap_f = tp;
            tap_f[WIDTH-1] = 1'b1;
            nxt = {cur[WIDTH-2:0], ^(cur & tap_f)};
        end else begin
            nxt = {cur[WIDTH-2:0], cur[WIDTH-1]}
                ^ ({tp[WIDTH-1:1], 1'b0} & {WIDTH{cur[WIDTH-1]}});
        end
        if (md[1]) begin
            nxt = nxt ^ din;
        end
        return nxt;
    endfunction

    assign opcode  = bus.instr[WIDTH+5:WIDTH];
    assign operand = bus.instr[WIDTH-1:0];

    // An all-zero register is a dead state for a plain LFSR; recover by
    // loading 1. A MISR can legitimately pass through zero, so no recovery.
    assign step_lock = (q == '0) && !mode[1];
    assign step_q    = step_lock ? WIDTH'(1) : lfsr_next(q, tap, mode, bus.data_in);

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        q_nxt      = q;
        tap_nxt    = tap;
        mode_nxt   = mode;
        r_addr_nxt = r_addr;
        cnt_nxt    = cnt;
        step_en    = 1'b0;
        ill_set    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_nxt = pc + PC_W'(1);
                case (opcode)
                    OP_CFG_TAP:   tap_nxt = operand;
                    OP_INIT_L:    q_nxt = operand;
                    OP_RUN: begin
                        // First step happens here; a count of 0 or 1 is a
                        // single step. Longer runs park pc and finish in RUN.
                        step_en = 1'b1;
                        q_nxt   = step_q;
                        if (operand > WIDTH'(1)) begin
                            pc_nxt    = pc;
                            cnt_nxt   = operand - WIDTH'(1);
                            state_nxt = S_RUN;
                        end
                    end
                    OP_STORE:     mem_we = 1'b1;
                    OP_LOAD:      q_nxt = mem[r_addr];
                    OP_INIT_ADDR: r_addr_nxt = ADDR_W'(operand);
                    OP_ADD_ADDR:  r_addr_nxt = r_addr + ADDR_W'(operand);
                    OP_SET_MODE:  mode_nxt = operand[1:0];
                    OP_HALT: begin
                        pc_nxt    = pc;
                        state_nxt = S_HALT;
                    end
                    default:      ill_set = 1'b1;
                endcase
            end
            S_RUN: begin
                // cnt holds the steps still to do, including this one
                step_en = 1'b1;
                q_nxt   = step_q;
                cnt_nxt = cnt - WIDTH'(1);
                if (cnt == WIDTH'(1)) begin
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = S_EXEC;
                end
            end
            S_HALT: begin
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            q        <= '0;
            tap      <= '0;
            mode     <= '0;
            r_addr   <= '0;
            cnt      <= '0;
            q_vld    <= 1'b0;
            lock_err <= 1'b0;
            ill_op   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            q        <= q_nxt;
            tap      <= tap_nxt;
            mode     <= mode_nxt;
            r_addr   <= r_addr_nxt;
            cnt      <= cnt_nxt;
            q_vld    <= step_en;
            lock_err <= lock_err | (step_en & step_lock);
            ill_op   <= ill_op | ill_set;
        end
    end

    // Pattern memory keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[r_addr] <= q;
        end
    end

    assign bus.pc       = pc;
    assign bus.q        = q;
    assign bus.r_addr   = r_addr;
    assign bus.q_vld    = q_vld;
    assign bus.busy     = (state == S_EXEC) || (state == S_RUN);
    assign bus.halted   = (state == S_HALT);
    assign bus.lock_err = lock_err;
    assign bus.ill_op   = ill_op;
endmodule

// File: tb/tb_lfsr_prpg_core.sv
`timescale 1ns/1ps
module tb_lfsr_prpg_core;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 256;
    localparam int PC_W   = 8;
    localparam int ADDR_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_prpg_core_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

    lfsr_prpg_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH+5:0] rom [256];
    assign bus.instr = rom[bus.pc];

    typedef struct {
        logic [7:0] q;
        logic [7:0] pc;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH+5:0] ins(input logic [5:0] op, input logic [7:0] od);
        return {op, od};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = ins(6'h3F, 8'h00);
    endtask

    task automatic push_exp(input logic [7:0] qv, input logic [7:0] pcv);
        exp_t e;
        e.q  = qv;
        e.pc = pcv;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 400; i++) begin
            if (bus.halted) break;
            @(negedge clk);
        end
        chk({name, "_halt_reached"}, 32'(bus.halted), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},       32'(bus.pc),       32'h0);
        chk({tag, "_q"},        32'(bus.q),        32'h0);
        chk({tag, "_r_addr"},   32'(bus.r_addr),   32'h0);
        chk({tag, "_q_vld"},    32'(bus.q_vld),    32'h0);
        chk({tag, "_busy"},     32'(bus.busy),     32'h0);
        chk({tag, "_halted"},   32'(bus.halted),   32'h0);
        chk({tag, "_lock_err"}, 32'(bus.lock_err), 32'h0);
        chk({tag, "_ill_op"},   32'(bus.ill_op),   32'h0);
    endtask

    // Monitor: every q_vld pulse must match the oldest expected step
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.q_vld) begin
                if (sb.size() == 0) begin
                    chk("q_vld_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("step_q",  32'(bus.q),  32'(e.q));
                    chk("step_pc", 32'(bus.pc), 32'(e.pc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.data_in = '0;
        clear_rom();
        rst_n = 1'b0;
        #12;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Galois single step: 0x80 with taps 0xFE -> 0xFF
        clear_rom();
        rom[0] = ins(6'h01, 8'hFE);
        rom[1] = ins(6'h02, 8'h80);
        rom[2] = ins(6'h03, 8'h01);
        do_reset();
        push_exp(8'hFF, 8'd3);
        pulse_start();
        chk("A_busy", 32'(bus.busy), 32'd1);
        wait_halt("A");
        chk("A_pc",       32'(bus.pc),       32'd3);
        chk("A_q",        32'(bus.q),        32'hFF);
        chk("A_busy_end", 32'(bus.busy),     32'd0);
        chk("A_lock_err", 32'(bus.lock_err), 32'd0);
        chk("A_ill_op",   32'(bus.ill_op),   32'd0);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("A_start_ignored_halted", 32'(bus.halted), 32'd1);
        chk("A_start_ignored_pc",     32'(bus.pc),     32'd3);

        // Fibonacci RUN 3: 0x01 -> 0x02, 0x04, 0x08, pc parked at 3
        clear_rom();
        rom[0] = ins(6'h08, 8'h01);
        rom[1] = ins(6'h01, 8'h00);
        rom[2] = ins(6'h02, 8'h01);
        rom[3] = ins(6'h03, 8'h03);
        do_reset();
        push_exp(8'h02, 8'd3);
        push_exp(8'h04, 8'd3);
        push_exp(8'h08, 8'd4);
        pulse_start();
        wait_halt("B");
        chk("B_pc", 32'(bus.pc), 32'd4);
        chk("B_q",  32'(bus.q),  32'h08);

        // Lockup recovery from zero
        clear_rom();
        rom[0] = ins(6'h02, 8'h00);
        rom[1] = ins(6'h03, 8'h01);
        do_reset();
        push_exp(8'h01, 8'd2);
        pulse_start();
        wait_halt("C");
        chk("C_q",        32'(bus.q),        32'h01);
        chk("C_lock_err", 32'(bus.lock_err), 32'd1);
        chk("C_pc",       32'(bus.pc),       32'd2);

        // MISR from zero: no lockup, result is data_in
        clear_rom();
        rom[0] = ins(6'h08, 8'h02);
        rom[1] = ins(6'h02, 8'h00);
        rom[2] = ins(6'h03, 8'h00);
        do_reset();
        bus.data_in = 8'h5A;
        push_exp(8'h5A, 8'd3);
        pulse_start();
        wait_halt("M");
        bus.data_in = '0;
        chk("M_q",        32'(bus.q),        32'h5A);
        chk("M_lock_err", 32'(bus.lock_err), 32'd0);

        // Memory store/load with address wrap
        clear_rom();
        rom[0] = ins(6'h06, 8'hFF);
        rom[1] = ins(6'h02, 8'h5A);
        rom[2] = ins(6'h04, 8'h00);
        rom[3] = ins(6'h07, 8'h02);
        rom[4] = ins(6'h02, 8'h00);
        rom[5] = ins(6'h07, 8'hFE);
        rom[6] = ins(6'h05, 8'h00);
        do_reset();
        pulse_start();
        wait_halt("D");
        chk("D_r_addr", 32'(bus.r_addr), 32'hFF);
        chk("D_q",      32'(bus.q),      32'h5A);
        chk("D_pc",     32'(bus.pc),     32'd7);

        // Memory contents survive reset
        clear_rom();
        rom[0] = ins(6'h06, 8'hFF);
        rom[1] = ins(6'h05, 8'h00);
        do_reset();
        pulse_start();
        wait_halt("R");
        chk("R_q_retained", 32'(bus.q), 32'h5A);

        // Reset during RUN 200 (Galois, taps 0 -> rotate left)
        clear_rom();
        rom[0] = ins(6'h01, 8'h00);
        rom[1] = ins(6'h02, 8'h01);
        rom[2] = ins(6'h03, 8'hC8);
        do_reset();
        push_exp(8'h02, 8'd2);
        push_exp(8'h04, 8'd2);
        push_exp(8'h08, 8'd2);
        push_exp(8'h10, 8'd2);
        push_exp(8'h20, 8'd2);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("F_steps_seen", 32'(sb.size()), 32'd0);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("F_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("F_idle_busy", 32'(bus.busy), 32'd0);
        chk("F_idle_pc",   32'(bus.pc),   32'd0);
        chk("F_idle_q",    32'(bus.q),    32'd0);

        // Illegal opcode, launched only by a fresh start
        clear_rom();
        rom[0] = ins(6'h2A, 8'h00);
        pulse_start();
        wait_halt("E");
        chk("E_ill_op", 32'(bus.ill_op), 32'd1);
        chk("E_pc",     32'(bus.pc),     32'd1);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lfsr_prpg_core.md
LFSR_PRPG_CORE -- requirements
Module: lfsr_prpg_core

Interface
REQ-001 Parameter WIDTH, default 8: LFSR/data word width, legal range 4..32.
REQ-002 Parameter DEPTH, default 256: pattern memory words, power of two; ADDR_W = clog2(DEPTH).
REQ-003 Parameter PC_W, default 8: program counter width; instruction word is 6+WIDTH bits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins execution from IDLE.
REQ-007 instr  input  6+WIDTH  instruction at pc, combinational from external ROM: opcode = [WIDTH+5:WIDTH], operand = [WIDTH-1:0].
REQ-008 data_in  input  WIDTH  MISR compaction data, sampled on every RUN step.
REQ-009 pc  output  PC_W  current instruction address.
REQ-010 q  output  WIDTH  LFSR register; q[0] is the LSB.
REQ-011 r_addr  output  ADDR_W  memory address register.
REQ-012 q_vld  output  1  high for exactly the cycle in which q holds a newly shifted value.
REQ-013 busy, halted, lock_err, ill_op  output  1 each  status flags; lock_err and ill_op are sticky.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, RUN and HALT: IDLE->EXEC on start; EXEC->RUN on RUN with count>1; RUN->EXEC after the last step; EXEC->HALT on HALT.
REQ-015 busy SHALL be 1 in EXEC and RUN only; halted SHALL be 1 in HALT only; start SHALL be ignored outside IDLE.
REQ-016 In EXEC, one instruction SHALL complete per cycle and pc SHALL advance by 1 (wrapping modulo 2^PC_W), except during RUN and HALT.
REQ-017 Opcode 0x01 CFG_TAP SHALL set tap <= operand; tap[0] is unused in Galois mode.
REQ-018 Opcode 0x02 INIT_L SHALL set q <= operand.
REQ-019 Opcode 0x03 RUN SHALL perform N = operand shift steps, one per cycle, with N=0 treated as 1; pc SHALL be held until the last step; the first step occurs in the EXEC cycle.
REQ-020 Galois step (mode[0]=0): q[0] <= q[W-1]; for i = 1..W-1, q[i] <= q[i-1] ^ (tap[i] & q[W-1]).
REQ-021 Fibonacci step (mode[0]=1): q <= {q[W-2:0], ^(q & tap_f)}, where tap_f is tap with bit W-1 forced to 1.
REQ-022 When mode[1]=1 (MISR), each step's next value SHALL additionally be XORed with data_in sampled in that cycle.
REQ-023 Lockup: if q==0 at the start of a step and mode[1]=0, q SHALL load 1 instead of shifting, and lock_err SHALL set.
REQ-024 Opcode 0x04 STORE SHALL write M[r_addr] <= q; opcode 0x05 LOAD SHALL set q <= M[r_addr] (a STORE followed by a LOAD of the same address returns the stored value).
REQ-025 Opcode 0x06 INIT_ADDR SHALL set r_addr <= operand[ADDR_W-1:0]; opcode 0x07 ADD_ADDR SHALL set r_addr <= r_addr + operand, wrapping modulo DEPTH.
REQ-026 Opcode 0x08 SET_MODE SHALL set mode <= operand[1:0]; the new mode takes effect from the next instruction.
REQ-027 Opcode 0x3F HALT SHALL freeze pc, q and r_addr; only reset leaves HALT.
REQ-028 Any other opcode SHALL act as a NOP (pc+1) and set ill_op.
REQ-029 q_vld SHALL pulse once per completed shift step, including a lockup-recovery load, and never for INIT_L or LOAD.
REQ-030 Memory contents SHALL NOT be reset and SHALL be retained across reset.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, pc=0, q=0, r_addr=0, tap=0, mode=0, q_vld=0, busy=0, halted=0, lock_err=0, ill_op=0.
REQ-032 Reset asserted mid-RUN SHALL abort the remaining steps; after release the core SHALL wait in IDLE for start.

Verification
REQ-033 WIDTH=8; program CFG_TAP 0xFE, INIT_L 0x80, RUN 1, HALT; start -> q=0xFF with one q_vld pulse; halted=1; pc=3.
REQ-034 WIDTH=8; program SET_MODE 1, CFG_TAP 0x00, INIT_L 0x01, RUN 3 -> q = 0x02, 0x04, 0x08 on consecutive cycles; pc held for 2 cycles.
REQ-035 INIT_L 0x00, RUN 1 -> q=0x01, lock_err=1, q_vld pulses once.
REQ-036 INIT_ADDR 0xFF, INIT_L 0x5A, STORE, ADD_ADDR 0x02, INIT_L 0x00, ADD_ADDR 0xFE, LOAD -> r_addr=0xFF, q=0x5A.
REQ-037 Opcode 0x2A executes -> ill_op=1, pc advances by 1; rst_n pulsed low during RUN 200 -> all outputs return to reset values; start is required to resume.
